// File: rtl/guess_controller_if.sv
// guess_controller_if
//   Groups the game-controller handshake and data signals into one bundle.
//   Signals:
//     start, digit_valid, digit[3:0], submit   player/environment -> controller
//     check_result[7:0]                        external checker  -> controller
//     start_check                              controller -> checker (1-cycle pulse)
//     input_number[11:0], target_number[11:0]  controller -> checker/display
//     result[7:0], tries[3:0]                  controller status
//     busy, win, lose                          state-decoded flags
//   Modports: master (environment side), slave (controller side).
interface guess_controller_if;
  logic        start;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        submit;
  logic [7:0]  check_result;
  logic        start_check;
  logic [11:0] input_number;
  logic [11:0] target_number;
  logic [7:0]  result;
  logic [3:0]  tries;
  logic        busy;
  logic        win;
  logic        lose;

  modport master (
    output start, digit_valid, digit, submit, check_result,
    input  start_check, input_number, target_number, result, tries, busy, win, lose
  );

  modport slave (
    input  start, digit_valid, digit, submit, check_result,
    output start_check, input_number, target_number, result, tries, busy, win, lose
  );
endinterface

// File: rtl/guess_controller.sv
// guess_controller
//   Three-digit number-guessing game controller. Generates a secret of three
//   distinct BCD digits from a free-running LFSR, collects player digits,
//   hands each complete guess to an external checker and tracks win/lose.
//   Parameters:
//     MAX_TRY     guesses allowed per game (1..15)
//     TIMEOUT_CYC per-guess cycle limit, only used when GUESS_TIMEOUT_EN is defined
//   Ports:
//     clk  rising-edge system clock
//     rst  asynchronous active-low reset (release is synchronised internally)
//     bus  guess_controller_if.slave handshake/data bundle
//   Optional feature macro: GUESS_TIMEOUT_EN (per-guess timeout in ENTRY).
module guess_controller #(
  parameter int unsigned MAX_TRY     = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic               clk,
  input logic               rst,
  guess_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GEN, ENTRY, CHECK, WAIT, EVAL, WIN, LOSE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_run;
  logic [7:0]  r_lfsr;
  logic [11:0] r_input;
  logic [11:0] r_target;
  logic [7:0]  r_result;
  logic [3:0]  r_tries;
  logic [1:0]  r_dcnt;
  logic [1:0]  r_gcnt;

  logic        w_lfsr_fb;
  logic [3:0]  w_cand;
  logic        w_cand_ok;
  logic        w_in_entry;
  logic        w_digit_ok;
  logic [1:0]  w_dcnt_upd;
  logic        w_submit_ok;
  logic        w_timeout;

  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_in_entry = (r_state == ENTRY);

  // Reset is asserted asynchronously but released through this flop, so all
  // other state stays frozen until the second rising edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;
  end

`ifdef GUESS_TIMEOUT_EN
  logic [31:0] r_tcnt;

  // Held at zero outside ENTRY, so it restarts on every entry to ENTRY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_tcnt <= '0;
    else if (r_run) r_tcnt <= w_in_entry ? r_tcnt + 32'd1 : '0;
  end

  assign w_timeout = w_in_entry && (r_tcnt == TIMEOUT_CYC - 1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cand      = r_lfsr[3:0];
    w_cand_ok   = (w_cand <= 4'd9);
    if ((r_gcnt != 2'd0) && (w_cand == r_target[3:0])) w_cand_ok = 1'b0;
    if ((r_gcnt == 2'd2) && (w_cand == r_target[7:4])) w_cand_ok = 1'b0;

    w_digit_ok = w_in_entry && bus.digit_valid && (bus.digit <= 4'd9);
    w_dcnt_upd = r_dcnt;
    if (w_digit_ok && (r_dcnt != 2'd3)) w_dcnt_upd = r_dcnt + 2'd1;
    // Submit sees the count including a digit strobed in the same cycle.
    w_submit_ok = w_in_entry && bus.submit && (w_dcnt_upd == 2'd3);

    case (r_state)
      IDLE, WIN, LOSE: if (bus.start) w_state_nxt = GEN;
      GEN:             if (w_cand_ok && (r_gcnt == 2'd2)) w_state_nxt = ENTRY;
      ENTRY: begin
        if (w_submit_ok)    w_state_nxt = CHECK;
        else if (w_timeout) w_state_nxt = EVAL;
      end
      CHECK:           w_state_nxt = WAIT;
      WAIT:            w_state_nxt = EVAL;
      EVAL: begin
        if (r_result == 8'b00_100_000)     w_state_nxt = WIN;
        else if (r_tries == 4'(MAX_TRY))   w_state_nxt = LOSE;
        else                               w_state_nxt = ENTRY;
      end
      default:         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_state <= IDLE;
    else if (r_run) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr   <= 8'hA5;
      r_input  <= '0;
      r_target <= '0;
      r_result <= '0;
      r_tries  <= '0;
      r_dcnt   <= '0;
      r_gcnt   <= '0;
    end else if (r_run) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      case (r_state)
        IDLE, WIN, LOSE: begin
          if (bus.start) begin
            r_input  <= '0;
            r_target <= '0;
            r_result <= '0;
            r_tries  <= '0;
            r_dcnt   <= '0;
            r_gcnt   <= '0;
          end
        end
        GEN: begin
          if (w_cand_ok) begin
            r_target <= {r_target[7:0], w_cand};
            r_gcnt   <= r_gcnt + 2'd1;
          end
        end
        ENTRY: begin
          if (w_digit_ok) r_input <= {r_input[7:0], bus.digit};
          r_dcnt <= w_dcnt_upd;
          if (w_timeout && !w_submit_ok) begin
            r_tries  <= r_tries + 4'd1;
            r_result <= '0;
          end
        end
        WAIT: begin
          r_result <= bus.check_result;
          r_tries  <= r_tries + 4'd1;
        end
        EVAL: begin
          if (w_state_nxt == ENTRY) r_dcnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.start_check   = (r_state == CHECK);
  assign bus.busy          = !((r_state == IDLE) || (r_state == WIN) || (r_state == LOSE));
  assign bus.win           = (r_state == WIN);
  assign bus.lose          = (r_state == LOSE);
  assign bus.input_number  = r_input;
  assign bus.target_number = r_target;
  assign bus.result        = r_result;
  assign bus.tries         = r_tries;

endmodule
